cnn16_mem_arbiter: RTL and testbench

Two-port arbiter that shares the single-port synchronous `cnn16_ram` between the 16-bit CPU (`top_cnn_alu`, port 0) and the convolution/DMA engine (port 1). It is inserted between the requesters and the RAM inside the `CNN_16` top level. It replaces the hard-wired `mem_ready = 1` with per-port ready/valid handshakes, and drives the RAM's `mem_write`, `address` and `data_in` from the winning requester. Port 1 has fixed priority, and a starvation cap guarantees the CPU forward progress.

---
 rtl/cnn16_mem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_cnn16_mem_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/cnn16_mem_arbiter.sv
// cnn16_mem_arbiter
//   Shares the single-port synchronous cnn16_ram between the CPU (port 0)
//   and the convolution/DMA engine (port 1). Port 1 has fixed priority; a
//   starvation counter forces a port-0 grant after MAX_BURST consecutive
//   port-1 grants while port 0 is waiting.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req0_* / req1_*               valid/ready request, write flag, address,
//                                 write data, plus read return (rvalid/rdata)
//   ram_mem_write/address/data_in RAM drive from the granted port
//   ram_data_out                  RAM read data (1-cycle registered latency)
//   busy                          a grant or a read return this cycle
module cnn16_mem_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 12,
  parameter int MAX_BURST  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic                  req0_write,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  req0_ready,
  output logic                  req0_rvalid,
  output logic [DATA_WIDTH-1:0] req0_rdata,
  input  logic                  req1_valid,
  input  logic                  req1_write,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  req1_ready,
  output logic                  req1_rvalid,
  output logic [DATA_WIDTH-1:0] req1_rdata,
  output logic                  ram_mem_write,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  input  logic [DATA_WIDTH-1:0] ram_data_out,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} owner_t;

  localparam logic [7:0] BURST_CAP = 8'(MAX_BURST);

  logic [1:0]            port_write;
  logic [1:0]            grant;
  logic [1:0]            rvalid;
  logic [1:0]            rd_pend_reg;
  logic [7:0]            starve_cnt_reg, starve_cnt_next;
  owner_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_hold_reg;
  logic [DATA_WIDTH-1:0] data_hold_reg;
  logic [DATA_WIDTH-1:0] rdata [2];

  assign port_write = {req1_write, req0_write};

  // Port 1 wins unless port 0 is waiting and has already watched a full
  // burst of port-1 grants go by.
  always_comb begin
    grant = 2'b00;
    if (!rst) begin
      if (req1_valid && (!req0_valid || (starve_cnt_reg < BURST_CAP)))
        grant = 2'b10;
      else if (req0_valid)
        grant = 2'b01;
    end
  end

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  // Counts port-1 grants that port 0 had to sit through; any cycle where
  // port 0 is served or not asking restarts the count.
  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (grant[0] || !req0_valid)
      starve_cnt_next = 8'd0;
    else if (grant[1] && (starve_cnt_reg < BURST_CAP))
      starve_cnt_next = starve_cnt_reg + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) starve_cnt_reg <= 8'd0;
    else     starve_cnt_reg <= starve_cnt_next;
  end

  // Read-pending flags plus the last granted address/data, which the RAM
  // bus keeps showing while nobody is granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend_reg   <= 2'b00;
      addr_hold_reg <= '0;
      data_hold_reg <= '0;
    end else begin
      rd_pend_reg <= grant & ~port_write;
      if (grant[1]) begin
        addr_hold_reg <= req1_addr;
        data_hold_reg <= req1_wdata;
      end else if (grant[0]) begin
        addr_hold_reg <= req0_addr;
        data_hold_reg <= req0_wdata;
      end
    end
  end

  always_comb begin
    ram_mem_write = |(grant & port_write);
    ram_address   = addr_hold_reg;
    ram_data_in   = data_hold_reg;
    if (rst) begin
      ram_address = '0;
      ram_data_in = '0;
    end else if (grant[1]) begin
      ram_address = req1_addr;
      ram_data_in = req1_wdata;
    end else if (grant[0]) begin
      ram_address = req0_addr;
      ram_data_in = req0_wdata;
    end
  end

  // Read return: the pending flag lines up with the RAM's registered output.
  // Reset masks a flag set by a read accepted just before reset rose.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ret
      assign rvalid[gi] = rd_pend_reg[gi] & ~rst;
      assign rdata[gi]  = rvalid[gi] ? ram_data_out : '0;
    end
  endgenerate

  assign req0_rvalid = rvalid[0];
  assign req1_rvalid = rvalid[1];
  assign req0_rdata  = rdata[0];
  assign req1_rdata  = rdata[1];

  // Owner FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Owner FSM: next state is whoever is granted now
  always_comb begin
    state_next = IDLE;
    if (grant[1])      state_next = OWN1;
    else if (grant[0]) state_next = OWN0;
  end

  // Owner FSM: outputs. A read return is only possible in the cycle after
  // some port owned the RAM.
  always_comb begin
    busy = 1'b0;
    if (!rst) begin
      case (state_reg)
        OWN0, OWN1: busy = (|grant) | (|rvalid);
        default:    busy = |grant;
      endcase
    end
  end

endmodule

// File: tb/tb_cnn16_mem_arbiter.sv
module tb_cnn16_mem_arbiter;
  localparam int DW = 16;
  localparam int AW = 12;
  localparam int MB = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req0_write, req0_ready, req0_rvalid;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata, req0_rdata;
  logic          req1_valid, req1_write, req1_ready, req1_rvalid;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata, req1_rdata;
  logic          ram_mem_write, busy;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data_in, ram_data_out;

  always #5 clk = ~clk;

  cnn16_mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready), .req0_rvalid(req0_rvalid),
    .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready), .req1_rvalid(req1_rvalid),
    .req1_rdata(req1_rdata),
    .ram_mem_write(ram_mem_write), .ram_address(ram_address),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out), .busy(busy)
  );

  // Single-port synchronous RAM standing in for cnn16_ram; cleared once
  // during the first reset cycle.
  logic [DW-1:0] ram [0:4095];
  logic [DW-1:0] ram_q;
  bit            ram_cleared = 1'b0;
  always @(posedge clk) begin
    if (rst && !ram_cleared) begin
      for (int i = 0; i < 4096; i++) ram[i] <= '0;
      ram_cleared <= 1'b1;
    end else if (ram_mem_write) begin
      ram[ram_address] <= ram_data_in;
    end
    ram_q <= ram[ram_address];
  end
  assign ram_data_out = ram_q;

  // Reference model state
  logic [DW-1:0] mem_model [0:4095];
  int            m_starve;
  bit            m_rv0, m_rv1;
  logic [DW-1:0] m_rd0, m_rd1;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  int            checks, failures;
  logic [AW-1:0] saddr [5];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check combinational outputs mid-cycle against
  // the model, then advance the model across the clock edge.
  task automatic step(input bit r, input bit v0, input bit w0, input logic [AW-1:0] a0,
                      input logic [DW-1:0] d0, input bit v1, input bit w1,
                      input logic [AW-1:0] a1, input logic [DW-1:0] d1, output int gnt);
    int            g;
    bit            ew;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    rst = r;
    req0_valid = v0; req0_write = w0; req0_addr = a0; req0_wdata = d0;
    req1_valid = v1; req1_write = w1; req1_addr = a1; req1_wdata = d1;
    if (r)                                  g = -1;
    else if (v1 && (!v0 || m_starve < MB)) g = 1;
    else if (v0)                            g = 0;
    else                                    g = -1;
    ew = 1'b0; ea = m_addr; ed = m_data;
    if (r) begin
      ea = '0; ed = '0;
    end else if (g == 1) begin
      ew = w1; ea = a1; ed = d1;
    end else if (g == 0) begin
      ew = w0; ea = a0; ed = d0;
    end
    @(negedge clk);
    chk("ready0", req0_ready, g == 0);
    chk("ready1", req1_ready, g == 1);
    chk("mem_write", ram_mem_write, ew);
    chk("ram_address", ram_address, ea);
    chk("ram_data_in", ram_data_in, ed);
    chk("rvalid0", req0_rvalid, !r && m_rv0);
    chk("rdata0", req0_rdata, (!r && m_rv0) ? m_rd0 : 16'h0);
    chk("rvalid1", req1_rvalid, !r && m_rv1);
    chk("rdata1", req1_rdata, (!r && m_rv1) ? m_rd1 : 16'h0);
    chk("busy", busy, !r && (g >= 0 || m_rv0 || m_rv1));
    @(posedge clk);
    if (r) begin
      m_starve = 0; m_rv0 = 0; m_rv1 = 0; m_addr = '0; m_data = '0;
    end else begin
      m_rv0 = (g == 0) && !w0;
      m_rv1 = (g == 1) && !w1;
      if (g == 0) begin
        if (w0) mem_model[a0] = d0; else m_rd0 = mem_model[a0];
      end
      if (g == 1) begin
        if (w1) mem_model[a1] = d1; else m_rd1 = mem_model[a1];
      end
      if (g >= 0) begin m_addr = ea; m_data = ed; end
      if (g == 0 || !v0)              m_starve = 0;
      else if (g == 1 && m_starve < MB) m_starve++;
    end
    #1;
    gnt = g;
  endtask

  initial begin
    int g;
    bit p0v, p0w, p1v, p1w, r;
    logic [AW-1:0] p0a, p1a;
    logic [DW-1:0] p0d, p1d;
    checks = 0; failures = 0;
    m_starve = 0; m_rv0 = 0; m_rv1 = 0; m_rd0 = '0; m_rd1 = '0; m_addr = '0; m_data = '0;
    for (int i = 0; i < 4096; i++) mem_model[i] = '0;
    saddr[0] = 12'h000; saddr[1] = 12'h001; saddr[2] = 12'h002;
    saddr[3] = 12'h003; saddr[4] = 12'hFFF;
    rst = 1'b1;
    req0_valid = 0; req0_write = 0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 0; req1_write = 0; req1_addr = '0; req1_wdata = '0;
    @(posedge clk); #1;

    // Reset: requests present but nothing may be granted
    step(1, 1, 1, 12'h123, 16'h5555, 1, 0, 12'h456, 16'h0, g);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, g);

    // Write then read on port 0
    step(0, 1, 1, 12'h010, 16'hBEEF, 0, 0, 0, 0, g);
    chk("wr0_grant", g, 0);
    step(0, 1, 0, 12'h010, 16'h0, 0, 0, 0, 0, g);
    chk("rd0_grant", g, 0);
    chk("rd0_rvalid", req0_rvalid, 1'b1);
    chk("rd0_rdata", req0_rdata, 16'hBEEF);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, g);

    // Contention: 27 cycles of reads on both ports
    for (int k = 0; k < 27; k++) begin
      step(0, 1, 0, 12'h020, 16'h0, 1, 0, 12'h030, 16'h0, g);
      chk($sformatf("contend_%0d", k), g, (k % 9 == 8) ? 0 : 1);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, g);

    // Port-1 streaming: preload, then back-to-back reads
    for (int i = 0; i < 5; i++)
      step(0, 0, 0, 0, 0, 1, 1, saddr[i], 16'h1000 + 16'(i), g);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 0, 1, 0, saddr[i], 16'h0, g);
      chk($sformatf("stream_grant_%0d", i), g, 1);
      chk($sformatf("stream_rvalid_%0d", i), req1_rvalid, 1'b1);
      chk($sformatf("stream_rdata_%0d", i), req1_rdata, 16'h1000 + 16'(i));
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, g);

    // Read-after-write across ports
    step(0, 1, 0, 12'h0A0, 16'h0, 1, 1, 12'h0A0, 16'h1234, g);
    chk("raw_first", g, 1);
    step(0, 1, 0, 12'h0A0, 16'h0, 0, 0, 0, 0, g);
    chk("raw_second", g, 0);
    chk("raw_rdata", req0_rdata, 16'h1234);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, g);

    // Reset mid-read
    step(0, 1, 0, 12'h010, 16'h0, 0, 0, 0, 0, g);
    chk("midrst_grant", g, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, g);
    chk("midrst_rvalid", req0_rvalid, 1'b0);
    step(0, 1, 0, 12'h010, 16'h0, 0, 0, 0, 0, g);
    chk("postrst_grant", g, 0);
    chk("postrst_rdata", req0_rdata, 16'hBEEF);

    // Idle for 10 cycles
    for (int k = 0; k < 10; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, g);
    chk("idle_ram_010", ram[12'h010], mem_model[12'h010]);
    chk("idle_ram_0a0", ram[12'h0A0], mem_model[12'h0A0]);
    chk("idle_ram_fff", ram[12'hFFF], mem_model[12'hFFF]);

    // Randomized traffic with held requests and occasional reset
    p0v = 0; p1v = 0; p0w = 0; p1w = 0; p0a = '0; p1a = '0; p0d = '0; p1d = '0;
    for (int n = 0; n < 400; n++) begin
      if (!p0v && $urandom_range(0, 99) < 60) begin
        p0v = 1; p0w = 1'($urandom_range(0, 1));
        p0a = ($urandom_range(0, 7) == 0) ? 12'hFFF : 12'($urandom_range(0, 15));
        p0d = 16'($urandom);
      end
      if (!p1v && $urandom_range(0, 99) < 80) begin
        p1v = 1; p1w = 1'($urandom_range(0, 1));
        p1a = ($urandom_range(0, 7) == 0) ? 12'hFFF : 12'($urandom_range(0, 15));
        p1d = 16'($urandom);
      end
      r = ($urandom_range(0, 99) == 0);
      step(r, p0v, p0w, p0a, p0d, p1v, p1w, p1a, p1d, g);
      if (g == 0) p0v = 0;
      if (g == 1) p1v = 0;
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, g);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
